// File: rtl/isp_pkg.sv
// Shared definitions for the image scaler pipeline: mode encoding and the
// default pixel width.
package isp_pkg;

  localparam int ISP_PIX_W_DEFAULT = 8;

  typedef logic [1:0] isp_mode_t;

  localparam isp_mode_t MODE_NEAREST  = 2'd0;
  localparam isp_mode_t MODE_BILINEAR = 2'd1;
  localparam isp_mode_t MODE_EDGE     = 2'd2;
  localparam isp_mode_t MODE_GRAD     = 2'd3;

endpackage

// File: rtl/isp_grad_unit.sv
// Combinational gradient helper: absolute differences of two pixel pairs,
// their maximum and strict-ordering flags. Ties leave both gt and lt low.
module isp_grad_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic [W-1:0] dx,
  output logic [W-1:0] dy,
  output logic [W-1:0] g,
  output logic         gt,
  output logic         lt
);

  assign dx = (a1 >= a0) ? (a1 - a0) : (a0 - a1);
  assign dy = (b1 >= b0) ? (b1 - b0) : (b0 - b1);
  assign g  = (dx >= dy) ? dx : dy;
  assign gt = (dx > dy);
  assign lt = (dx < dy);

endmodule

// File: rtl/image_scaler_pipe.sv
// Streaming 2x2-window interpolator, three register stages, valid/ready on
// both sides. The whole pipe freezes while the output is stalled.
// Optional build macro: ISP_SHARPEN_EN adds g>>2 (saturating) to modes 1/2.
module image_scaler_pipe
  import isp_pkg::*;
#(
  parameter int PIX_W  = ISP_PIX_W_DEFAULT,
  parameter int LINE_W = 640,
  parameter int COL_W  = $clog2(LINE_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [1:0]       in_mode,
  input  logic [PIX_W-1:0] t1,
  input  logic [PIX_W-1:0] t2,
  input  logic [PIX_W-1:0] t3,
  input  logic [PIX_W-1:0] t4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof,
  output logic             out_eol
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [PIX_W-1:0] ZERO_PIX = {PIX_W{1'b0}};

  logic             stall_s, advance_s, accept_s;
  logic [COL_W-1:0] col_r, beat_col_s;

  // stage 1
  logic             v1_r, sof1_r, eol1_r;
  isp_mode_t        mode1_r;
  logic [PIX_W-1:0] dx1_r, dy1_r, t1_1_r;
  logic [PIX_W:0]   sum_h1_r, sum_v1_r;
  logic [PIX_W-1:0] dx_s, dy_s;
  logic [PIX_W-1:0] unused_g1_s;
  logic             unused_gt1_s, unused_lt1_s;

  // stage 2
  logic             v2_r, sof2_r, eol2_r, gt2_r, lt2_r;
  isp_mode_t        mode2_r;
  logic [PIX_W-1:0] g2_r, t1_2_r;
  logic [PIX_W:0]   sum_h2_r, sum_v2_r;
  logic [PIX_W+1:0] total2_r;
  logic [PIX_W-1:0] g_s, unused_dx2_s, unused_dy2_s;
  logic             gt_s, lt_s;

  // stage 3
  logic [PIX_W-1:0] avg_s, half_h_s, half_v_s, interp_s, result_s;
  logic             out_valid_r, out_sof_r, out_eol_r;
  logic [PIX_W-1:0] out_pix_r;

  assign stall_s   = out_valid_r & ~out_ready;
  assign advance_s = ~stall_s;
  assign in_ready  = advance_s;
  assign accept_s  = in_valid & advance_s;

  assign out_valid = out_valid_r;
  assign out_pix   = out_pix_r;
  assign out_sof   = out_sof_r;
  assign out_eol   = out_eol_r;

  // Column of the beat being accepted: sof restarts the line, else wrap-increment.
  always_comb begin
    beat_col_s = col_r;
    if (in_sof) begin
      beat_col_s = {COL_W{1'b0}};
    end else if (col_r == LAST_COL) begin
      beat_col_s = {COL_W{1'b0}};
    end else begin
      beat_col_s = col_r + COL_W'(1'b1);
    end
  end

  // Column counter moves only on an accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r <= {COL_W{1'b0}};
    end else if (accept_s) begin
      col_r <= beat_col_s;
    end
  end

  isp_grad_unit #(.W(PIX_W)) u_grad_s1 (
    .a0(t1), .a1(t3), .b0(t2), .b1(t4),
    .dx(dx_s), .dy(dy_s), .g(unused_g1_s), .gt(unused_gt1_s), .lt(unused_lt1_s)
  );

  // Stage 1: differences, pair sums and per-beat tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      sof1_r   <= 1'b0;
      eol1_r   <= 1'b0;
      mode1_r  <= MODE_NEAREST;
      dx1_r    <= ZERO_PIX;
      dy1_r    <= ZERO_PIX;
      t1_1_r   <= ZERO_PIX;
      sum_h1_r <= {(PIX_W+1){1'b0}};
      sum_v1_r <= {(PIX_W+1){1'b0}};
    end else if (advance_s) begin
      v1_r     <= in_valid;
      sof1_r   <= in_sof;
      eol1_r   <= (beat_col_s == LAST_COL);
      mode1_r  <= in_mode;
      dx1_r    <= dx_s;
      dy1_r    <= dy_s;
      t1_1_r   <= t1;
      sum_h1_r <= {1'b0, t1} + {1'b0, t3};
      sum_v1_r <= {1'b0, t2} + {1'b0, t4};
    end
  end

  // Feeding (0,dx),(0,dy) reuses the unit for max and ordering of the differences.
  isp_grad_unit #(.W(PIX_W)) u_grad_s2 (
    .a0(ZERO_PIX), .a1(dx1_r), .b0(ZERO_PIX), .b1(dy1_r),
    .dx(unused_dx2_s), .dy(unused_dy2_s), .g(g_s), .gt(gt_s), .lt(lt_s)
  );

  // Stage 2: gradient magnitude, direction flags and the four-pixel total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_r     <= 1'b0;
      sof2_r   <= 1'b0;
      eol2_r   <= 1'b0;
      gt2_r    <= 1'b0;
      lt2_r    <= 1'b0;
      mode2_r  <= MODE_NEAREST;
      g2_r     <= ZERO_PIX;
      t1_2_r   <= ZERO_PIX;
      sum_h2_r <= {(PIX_W+1){1'b0}};
      sum_v2_r <= {(PIX_W+1){1'b0}};
      total2_r <= {(PIX_W+2){1'b0}};
    end else if (advance_s) begin
      v2_r     <= v1_r;
      sof2_r   <= sof1_r;
      eol2_r   <= eol1_r;
      gt2_r    <= gt_s;
      lt2_r    <= lt_s;
      mode2_r  <= mode1_r;
      g2_r     <= g_s;
      t1_2_r   <= t1_1_r;
      sum_h2_r <= sum_h1_r;
      sum_v2_r <= sum_v1_r;
      total2_r <= {1'b0, sum_h1_r} + {1'b0, sum_v1_r};
    end
  end

  // Rounded averages; every quotient fits PIX_W bits so truncation is exact.
  assign avg_s    = PIX_W'((total2_r + (PIX_W+2)'(2'd2)) >> 2);
  assign half_h_s = PIX_W'((sum_h2_r + (PIX_W+1)'(1'b1)) >> 1);
  assign half_v_s = PIX_W'((sum_v2_r + (PIX_W+1)'(1'b1)) >> 1);

  // Interpolated value: edge mode averages along the flatter direction.
  always_comb begin
    interp_s = avg_s;
    case (mode2_r)
      MODE_EDGE: begin
        if (gt2_r) begin
          interp_s = half_v_s;
        end else if (lt2_r) begin
          interp_s = half_h_s;
        end else begin
          interp_s = avg_s;
        end
      end
      default: interp_s = avg_s;
    endcase
  end

`ifdef ISP_SHARPEN_EN
  logic [PIX_W:0]   sharp_wide_s;
  logic [PIX_W-1:0] sharp_s;
  assign sharp_wide_s = {1'b0, interp_s} + {1'b0, (g2_r >> 2)};
  assign sharp_s      = sharp_wide_s[PIX_W] ? {PIX_W{1'b1}} : sharp_wide_s[PIX_W-1:0];
`else
  logic [PIX_W-1:0] sharp_s;
  assign sharp_s = interp_s;
`endif

  // Final result selection by the beat's own mode.
  always_comb begin
    result_s = t1_2_r;
    case (mode2_r)
      MODE_NEAREST:  result_s = t1_2_r;
      MODE_BILINEAR: result_s = sharp_s;
      MODE_EDGE:     result_s = sharp_s;
      MODE_GRAD:     result_s = g2_r;
      default:       result_s = t1_2_r;
    endcase
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_pix_r   <= ZERO_PIX;
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= v2_r;
      out_pix_r   <= result_s;
      out_sof_r   <= sof2_r;
      out_eol_r   <= eol2_r;
    end
  end

endmodule

// File: tb/tb_image_scaler_pipe.sv
// Directed self-checking bench for image_scaler_pipe (PIX_W=8, LINE_W=4).
module tb_image_scaler_pipe;
  import isp_pkg::*;

  localparam int PIX_W  = 8;
  localparam int LINE_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sof = 1'b0;
  logic [1:0]       in_mode = 2'd0;
  logic [PIX_W-1:0] t1 = '0, t2 = '0, t3 = '0, t4 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_pix;
  logic             out_sof;
  logic             out_eol;

  int tests_run = 0;
  int tests_failed = 0;

  image_scaler_pipe #(.PIX_W(PIX_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_mode(in_mode),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, run %0d failed %0d", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_pix !== 8'd0) begin tests_failed++; $display("FAIL reset_out_pix: got %0d want 0", out_pix); end
    tests_run++; if (out_sof !== 1'b0 || out_eol !== 1'b0) begin tests_failed++; $display("FAIL reset_tags: got sof=%b eol=%b want 0 0", out_sof, out_eol); end
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // One beat into an empty pipe: checks accept, exact 3-cycle latency, one-cycle valid.
  task automatic run_single(input string name, input logic [1:0] mode,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] expv);
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b0; in_mode = mode;
    t1 = a; t2 = b; t3 = c; t4 = d; out_ready = 1'b1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_accept: in_ready got %b want 1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_early: out_valid got %b want 0 at cycle %0d", name, out_valid, k); end
      @(negedge clk);
    end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
    tests_run++; if (out_pix !== expv) begin tests_failed++; $display("FAIL %s_pix: got %0d want %0d", name, out_pix, expv); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_pulse: out_valid got %b want 0", name, out_valid); end
  endtask

  task automatic test_modes();
`ifdef ISP_SHARPEN_EN
    run_single("bilinear",  MODE_BILINEAR, 8'd10, 8'd20, 8'd30, 8'd41, 8'd30);
    run_single("edge_h",    MODE_EDGE,     8'd0, 8'd100, 8'd200, 8'd110, 8'd155);
    run_single("edge_v",    MODE_EDGE,     8'd50, 8'd0, 8'd50, 8'd90, 8'd72);
    run_single("edge_tie",  MODE_EDGE,     8'd0, 8'd0, 8'd8, 8'd8, 8'd6);
`else
    run_single("bilinear",  MODE_BILINEAR, 8'd10, 8'd20, 8'd30, 8'd41, 8'd25);
    run_single("edge_h",    MODE_EDGE,     8'd0, 8'd100, 8'd200, 8'd110, 8'd105);
    run_single("edge_v",    MODE_EDGE,     8'd50, 8'd0, 8'd50, 8'd90, 8'd50);
    run_single("edge_tie",  MODE_EDGE,     8'd0, 8'd0, 8'd8, 8'd8, 8'd4);
`endif
    run_single("grad",      MODE_GRAD,     8'd250, 8'd7, 8'd5, 8'd9, 8'd245);
    run_single("nearest",   MODE_NEAREST,  8'd77, 8'd1, 8'd2, 8'd3, 8'd77);
  endtask

  task automatic test_sharpen();
`ifdef ISP_SHARPEN_EN
    run_single("sharp_sat", MODE_BILINEAR, 8'd255, 8'd255, 8'd0, 8'd255, 8'd254);
`else
    run_single("sharp_sat", MODE_BILINEAR, 8'd255, 8'd255, 8'd0, 8'd255, 8'd191);
`endif
    run_single("sharp_max", MODE_BILINEAR, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
  endtask

  // Six beats, alternating nearest/grad, out_ready low in loop cycles 4..6.
  task automatic test_back_to_back();
    logic [7:0] expv [6];
    logic [7:0] got [6];
    int idx, n_out;
    logic prev_stall;
    logic [7:0] prev_pix;
    logic exp_ready;
    expv[0] = 8'd5;  expv[1] = 8'd240; expv[2] = 8'd25;
    expv[3] = 8'd220; expv[4] = 8'd45; expv[5] = 8'd200;
    idx = 0; n_out = 0; prev_stall = 1'b0; prev_pix = 8'd0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_sof = 1'b0;
      if (idx < 6) begin
        in_valid = 1'b1;
        in_mode  = (idx % 2 == 1) ? MODE_GRAD : MODE_NEAREST;
        t1 = 8'(idx * 10 + 5); t3 = 8'd255; t2 = 8'd0; t4 = 8'(idx * 3);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ready = !(c >= 4 && c <= 6);
      tests_run++; if (in_ready !== exp_ready) begin tests_failed++; $display("FAIL b2b_in_ready: cycle %0d got %b want %b", c, in_ready, exp_ready); end
      if (prev_stall) begin
        tests_run++; if (out_valid !== 1'b1 || out_pix !== prev_pix) begin tests_failed++; $display("FAIL b2b_hold: cycle %0d got valid=%b pix=%0d want 1 %0d", c, out_valid, out_pix, prev_pix); end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (n_out < 6) got[n_out] = out_pix;
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pix = out_pix;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests_run++; if (idx !== 6) begin tests_failed++; $display("FAIL b2b_accepted: got %0d want 6", idx); end
    tests_run++; if (n_out !== 6) begin tests_failed++; $display("FAIL b2b_count: got %0d want 6", n_out); end
    for (int i = 0; i < 6; i++) begin
      if (i < n_out) begin
        tests_run++; if (got[i] !== expv[i]) begin tests_failed++; $display("FAIL b2b_pix%0d: got %0d want %0d", i, got[i], expv[i]); end
      end
    end
  endtask

  // Nine beats with a given sof mask; expects order plus sof/eol per beat.
  task automatic run_line(input string name, input logic [8:0] sof_mask, input logic [8:0] eol_exp);
    int idx, n_out;
    idx = 0; n_out = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (idx < 9) begin
        in_valid = 1'b1; in_mode = MODE_NEAREST; in_sof = sof_mask[idx];
        t1 = 8'(idx); t2 = 8'd0; t3 = 8'd0; t4 = 8'd0;
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (n_out < 9) begin
          tests_run++; if (out_pix !== 8'(n_out)) begin tests_failed++; $display("FAIL %s_order%0d: got %0d want %0d", name, n_out, out_pix, n_out); end
          tests_run++; if (out_sof !== sof_mask[n_out]) begin tests_failed++; $display("FAIL %s_sof%0d: got %b want %b", name, n_out, out_sof, sof_mask[n_out]); end
          tests_run++; if (out_eol !== eol_exp[n_out]) begin tests_failed++; $display("FAIL %s_eol%0d: got %b want %b", name, n_out, out_eol, eol_exp[n_out]); end
        end
        n_out++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    tests_run++; if (n_out !== 9) begin tests_failed++; $display("FAIL %s_count: got %0d want 9", name, n_out); end
  endtask

  task automatic test_sof_eol();
    run_line("line_a", 9'b000000001, 9'b010001000);
    run_line("line_b", 9'b000100001, 9'b100001000);
  endtask

  // Two beats in flight, one-cycle reset: nothing may emerge afterwards.
  task automatic test_reset_flush();
    @(negedge clk);
    in_valid = 1'b1; in_mode = MODE_NEAREST; in_sof = 1'b1; t1 = 8'd9; out_ready = 1'b1;
    @(negedge clk);
    in_sof = 1'b0; t1 = 8'd10;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tests_run++; if (out_pix !== 8'd0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin tests_failed++; $display("FAIL flush_outputs: got pix=%0d sof=%b eol=%b want 0 0 0", out_pix, out_sof, out_eol); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_quiet%0d: out_valid got %b want 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_sof_eol();
    test_sharpen();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
